// File: rtl/regfile_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared widths, opcode and state encodings for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_LI  = 3'b110,
        OP_MOV = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sequencer_if
// Brief    : Command handshake plus register-file port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_sequencer_if
    import regfile_pkg::*;
#(
    parameter int N = 8
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [REG_ADDR_W-1:0] cmd_rd;
    logic [REG_ADDR_W-1:0] cmd_rs;
    logic [REG_ADDR_W-1:0] cmd_rt;
    logic [N-1:0]          cmd_imm;
    logic                  clr;
    logic [REG_ADDR_W-1:0] ra1;
    logic [REG_ADDR_W-1:0] ra2;
    logic [N-1:0]          rd1;
    logic [N-1:0]          rd2;
    logic [REG_ADDR_W-1:0] wa3;
    logic [N-1:0]          wd3;
    logic                  we3;
    logic                  done;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm, clr, rd1, rd2,
        input  cmd_ready, ra1, ra2, wa3, wd3, we3, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm, clr, rd1, rd2,
        output cmd_ready, ra1, ra2, wa3, wd3, we3, done, busy
    );

endinterface
`default_nettype wire

// File: rtl/regfile_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module   : regfile_alu
// Brief    : Combinational N-bit ALU; arithmetic wraps modulo 2^N.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_alu
    import regfile_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] imm,
    input  op_t          op,
    output logic [N-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = {{(N-1){1'b0}}, (a < b)};
            OP_LI:   y = imm;
            OP_MOV:  y = a;
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sequencer
// Brief    : Multi-cycle READ/EXEC/WRITE sequencer driving a 3-port regfile.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    regfile_sequencer_if.slave bus
);

    localparam logic [REG_ADDR_W-1:0] c_CNT_FIRST = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] c_CNT_LAST  = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    op_t                   r_op;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_cnt;
    logic [N-1:0]          r_imm;
    logic [N-1:0]          r_opa;
    logic [N-1:0]          r_opb;
    logic [N-1:0]          r_result;
    logic [N-1:0]          w_alu_y;
    logic                  w_accept;

    assign w_accept = !rst && (r_state == ST_IDLE) && bus.cmd_valid;

    regfile_alu #(.N(N)) u_alu (
        .a   (r_opa),
        .b   (r_opb),
        .imm (r_imm),
        .op  (r_op),
        .y   (w_alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending command takes priority over a clear request in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_cnt == c_CNT_LAST) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_state_nxt = ST_READ;
                end else if (bus.clr) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_READ:  w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= c_CNT_FIRST;
            r_op     <= OP_ADD;
            r_rd     <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_imm    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else begin
            // Counter parks at 1 outside CLEAR so every clear walk starts at r1.
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + c_CNT_FIRST;
            end else begin
                r_cnt <= c_CNT_FIRST;
            end
            if (w_accept) begin
                r_op  <= op_t'(bus.cmd_op);
                r_rd  <= bus.cmd_rd;
                r_rs  <= bus.cmd_rs;
                r_rt  <= bus.cmd_rt;
                r_imm <= bus.cmd_imm;
            end
            if (r_state == ST_READ) begin
                r_opa <= bus.rd1;
                r_opb <= bus.rd2;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_alu_y;
            end
        end
    end

    // While rst is high every port is forced quiet so an aborted command never writes back.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.ra1       = '0;
        bus.ra2       = '0;
        bus.wa3       = '0;
        bus.wd3       = '0;
        bus.we3       = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = (r_state != ST_IDLE);
        if (rst) begin
            bus.busy = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: bus.cmd_ready = 1'b1;
                ST_READ: begin
                    bus.ra1 = r_rs;
                    bus.ra2 = r_rt;
                end
                ST_WRITE: begin
                    bus.wa3  = r_rd;
                    bus.wd3  = r_result;
                    bus.we3  = (r_rd != '0);
                    bus.done = 1'b1;
                end
                ST_CLEAR: begin
                    bus.wa3 = r_cnt;
                    bus.we3 = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sequencer
// Brief    : Scoreboard bench with a behavioural 8x8 regfile (r0 reads zero).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;

    typedef struct {
        logic [2:0] wa;
        logic [7:0] wd;
        logic       we;
        logic       dn;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem [8];
    exp_t       sb [$];
    exp_t       e;
    int         cyc_cnt = 0;
    int         n_cmp   = 0;
    int         n_err   = 0;

    regfile_sequencer_if #(.N(8)) bus ();

    regfile_sequencer #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clk) begin
        if (bus.we3 && bus.wa3 != 3'd0) mem[bus.wa3] <= bus.wd3;
    end
    assign bus.rd1 = (bus.ra1 == 3'd0) ? 8'h00 : mem[bus.ra1];
    assign bus.rd2 = (bus.ra2 == 3'd0) ? 8'h00 : mem[bus.ra2];

    function automatic logic [7:0] rdreg(input int a);
        return (a == 0) ? 8'h00 : mem[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_clear(input int first_cyc);
        for (int i = 1; i <= 7; i++) begin
            sb.push_back('{wa: 3'(i), wd: 8'h00, we: 1'b1, dn: 1'b0, cyc: first_cyc + i - 1});
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [7:0] imm, input logic [7:0] exp_wd,
                          input bit wb, input bit hold, output int acc_cyc);
        int w = 0;
        acc_cyc     = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op  = op;
        bus.cmd_rd  = rd;
        bus.cmd_rs  = rs;
        bus.cmd_rt  = rt;
        bus.cmd_imm = imm;
        while (bus.cmd_ready !== 1'b1) begin
            tick();
            w++;
            if (w > 40) begin
                chk("accept_timeout", 32'(w), 32'd0);
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        acc_cyc = cyc_cnt;
        if (wb) sb.push_back('{wa: rd, wd: exp_wd, we: (rd != 3'd0), dn: 1'b1, cyc: cyc_cnt + 3});
        tick();
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (bus.cmd_ready !== 1'b1) begin
            tick();
            w++;
            if (w > 40) begin
                chk("idle_timeout", 32'(w), 32'd0);
                return;
            end
        end
    endtask

    // Every write-port or done activity must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.we3 === 1'b1 || bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", {24'd0, 2'b00, bus.done, bus.we3, 1'b0, bus.wa3}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_wa3", 32'(bus.wa3), 32'(e.wa));
                chk("wb_we3", 32'(bus.we3), 32'(e.we));
                chk("wb_wd3", 32'(bus.wd3), 32'(e.wd));
                chk("wb_done", 32'(bus.done), 32'(e.dn));
                chk("wb_cycle", 32'(cyc_cnt), 32'(e.cyc));
                chk("wb_busy", 32'(bus.busy), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a3, t;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op  = 3'd0;
        bus.cmd_rd  = 3'd0;
        bus.cmd_rs  = 3'd0;
        bus.cmd_rt  = 3'd0;
        bus.cmd_imm = 8'h00;
        bus.clr     = 1'b0;

        tick();
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_we3",   32'(bus.we3), 32'd0);
        chk("rst_wa3",   32'(bus.wa3), 32'd0);
        chk("rst_wd3",   32'(bus.wd3), 32'd0);
        chk("rst_ra",    {bus.ra1, bus.ra2}, 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd1);
        tick();
        tick();
        push_clear(cyc_cnt);
        rst = 1'b0;
        wait_idle();
        chk("post_clear_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("clear_r%0d", i), 32'(rdreg(i)), 32'd0);

        do_cmd(3'b110, 3'd1, 3'd0, 3'd0, 8'hAB, 8'hAB, 1'b1, 1'b0, t);
        do_cmd(3'b110, 3'd2, 3'd0, 3'd0, 8'h55, 8'h55, 1'b1, 1'b0, t);
        do_cmd(3'b000, 3'd3, 3'd1, 3'd2, 8'h00, 8'h00, 1'b1, 1'b0, t);
        wait_idle();
        chk("r1_li", 32'(rdreg(1)), 32'h00AB);
        chk("r3_add_wrap", 32'(rdreg(3)), 32'h0000);

        do_cmd(3'b110, 3'd1, 3'd0, 3'd0, 8'h01, 8'h01, 1'b1, 1'b0, t);
        do_cmd(3'b001, 3'd4, 3'd0, 3'd1, 8'h00, 8'hFF, 1'b1, 1'b0, t);
        do_cmd(3'b101, 3'd5, 3'd1, 3'd4, 8'h00, 8'h01, 1'b1, 1'b0, t);
        do_cmd(3'b110, 3'd6, 3'd0, 3'd0, 8'h33, 8'h33, 1'b1, 1'b0, t);
        do_cmd(3'b100, 3'd6, 3'd4, 3'd4, 8'h00, 8'h00, 1'b1, 1'b0, t);
        do_cmd(3'b110, 3'd0, 3'd0, 3'd0, 8'h7F, 8'h7F, 1'b1, 1'b0, t);
        wait_idle();
        chk("r4_sub_borrow", 32'(rdreg(4)), 32'h00FF);
        chk("r5_slt", 32'(rdreg(5)), 32'h0001);
        chk("r6_xor", 32'(rdreg(6)), 32'h0000);
        chk("r0_readonly", 32'(rdreg(0)), 32'h0000);

        do_cmd(3'b111, 3'd7, 3'd5, 3'd0, 8'h00, 8'h01, 1'b1, 1'b1, a0);
        do_cmd(3'b000, 3'd2, 3'd2, 3'd2, 8'h00, 8'hAA, 1'b1, 1'b1, a1);
        do_cmd(3'b011, 3'd1, 3'd1, 3'd2, 8'h00, 8'hAB, 1'b1, 1'b1, a2);
        do_cmd(3'b010, 3'd3, 3'd1, 3'd2, 8'h00, 8'hAA, 1'b1, 1'b0, a3);
        chk("b2b_gap1", 32'(a1 - a0), 32'd4);
        chk("b2b_gap2", 32'(a2 - a1), 32'd4);
        chk("b2b_gap3", 32'(a3 - a2), 32'd4);
        wait_idle();
        chk("r7_mov", 32'(rdreg(7)), 32'h0001);
        chk("r2_add", 32'(rdreg(2)), 32'h00AA);
        chk("r1_or", 32'(rdreg(1)), 32'h00AB);
        chk("r3_and", 32'(rdreg(3)), 32'h00AA);

        do_cmd(3'b000, 3'd7, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, t);
        tick();
        rst = 1'b1;
        tick();
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_we3", 32'(bus.we3), 32'd0);
        push_clear(cyc_cnt);
        rst = 1'b0;
        wait_idle();
        for (int i = 1; i < 8; i++) chk($sformatf("abort_clear_r%0d", i), 32'(rdreg(i)), 32'd0);

        bus.clr = 1'b1;
        do_cmd(3'b110, 3'd2, 3'd0, 3'd0, 8'h5A, 8'h5A, 1'b1, 1'b0, t);
        bus.clr = 1'b0;
        wait_idle();
        tick();
        chk("clr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("clr_cmd_r2", 32'(rdreg(2)), 32'h005A);

        bus.clr = 1'b1;
        push_clear(cyc_cnt + 1);
        tick();
        bus.clr = 1'b0;
        chk("clr_busy", 32'(bus.busy), 32'd1);
        wait_idle();
        chk("clr_r2", 32'(rdreg(2)), 32'h0000);

        repeat (4) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
